// File: rtl/dll_pkg.sv
// ---------------------------------------------------------------------------
// dll_pkg: items shared by the DLL code controller.
//   - dll_state_e : controller FSM state encoding
//   - *_DEF       : default values for the dll_code_ctrl parameters
//   - cnt_w()     : width of a counter that must hold 0..max_val
// ---------------------------------------------------------------------------
package dll_pkg;

  localparam int CODE_W_DEF   = 6;   // delay-line control code width
  localparam int WIN_DEF      = 8;   // PD integration window (power of two)
  localparam int TH_DEF       = 3;   // net up/dn count for one code step
  localparam int LOCK_CNT_DEF = 4;   // quiet windows needed to declare lock
  localparam int HOLD_CYC_DEF = 16;  // settle cycles after init / recovery

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_TRACK   = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_RECOVER = 2'd3
  } dll_state_e;

  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sync2.sv
// ---------------------------------------------------------------------------
// sync2: two-flop synchronizer for a single asynchronous level input.
//   clk : destination clock
//   rst : asynchronous active-high reset, loads both flops with RST_VAL
//   d   : asynchronous input
//   q   : synchronized output, two clk edges of latency
// ---------------------------------------------------------------------------
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_d, s1_q;
  logic s2_d, s2_q;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/dll_code_ctrl.sv
// ---------------------------------------------------------------------------
// dll_code_ctrl: digital DLL delay-code controller.
// Integrates phase-detector up/dn pulses over fixed windows and steps the
// delay code by at most one per window; declares lock after LOCK_CNT quiet
// windows and restarts from code 0 when the harmonic-lock detector fires.
//   clk_ext  : single clock, all state on the rising edge
//   rst      : asynchronous active-high reset
//   Reset_PD : harmonic-lock detector (async, low = false lock detected)
//   up, dn   : phase-detector pulses (delay too short / too long)
//   dcode    : delay-line control code (registered)
//   pd_en    : phase-detector enable, low holds the PD in reset (registered)
//   locked   : lock indication (registered)
// ---------------------------------------------------------------------------
module dll_code_ctrl
  import dll_pkg::*;
#(
  parameter int CODE_W   = CODE_W_DEF,
  parameter int WIN      = WIN_DEF,
  parameter int TH       = TH_DEF,
  parameter int LOCK_CNT = LOCK_CNT_DEF,
  parameter int HOLD_CYC = HOLD_CYC_DEF
) (
  input  logic              clk_ext,
  input  logic              rst,
  input  logic              Reset_PD,
  input  logic              up,
  input  logic              dn,
  output logic [CODE_W-1:0] dcode,
  output logic              pd_en,
  output logic              locked
);

  localparam int WIN_W  = cnt_w(WIN - 1);
  localparam int ACC_W  = $clog2(WIN) + 2;  // |acc| <= WIN always fits
  localparam int LOCK_W = cnt_w(LOCK_CNT);
  localparam int HOLD_W = cnt_w(HOLD_CYC - 1);

  localparam logic        [WIN_W-1:0]  WIN_LAST  = WIN_W'(WIN - 1);
  localparam logic        [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);
  localparam logic        [LOCK_W-1:0] LOCK_TGT  = LOCK_W'(LOCK_CNT);
  localparam logic        [CODE_W-1:0] CODE_MAX  = '1;
  localparam logic signed [ACC_W-1:0]  ACC_ONE   = ACC_W'(1);
  localparam logic signed [ACC_W-1:0]  TH_POS    = ACC_W'(TH);
  localparam logic signed [ACC_W-1:0]  TH_NEG    = -TH_POS;

  dll_state_e               state_d, state_q;
  logic        [CODE_W-1:0] dcode_d, dcode_q;
  logic                     pd_en_d, pd_en_q;
  logic                     locked_d, locked_q;
  logic signed [ACC_W-1:0]  acc_d, acc_q;
  logic        [WIN_W-1:0]  win_d, win_q;
  logic        [LOCK_W-1:0] lock_d, lock_q;
  logic        [HOLD_W-1:0] hold_d, hold_q;

  logic                     rpd_sync;
  logic                     harm;
  logic signed [ACC_W-1:0]  acc_sum;
  logic                     win_end;
  logic                     step_up;
  logic                     step_dn;

  // Synchronizer idles at 1 through reset so no false harmonic is seen.
  sync2 #(.RST_VAL(1'b1)) u_sync_rpd (
    .clk (clk_ext),
    .rst (rst),
    .d   (Reset_PD),
    .q   (rpd_sync)
  );

  assign harm = ~rpd_sync;

  // NOTE: every signal written below gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    dcode_d = dcode_q;
    acc_d   = acc_q;
    win_d   = win_q;
    lock_d  = lock_q;
    hold_d  = hold_q;

    // Current sample folded in, so the decision at the last window slot
    // sees all WIN samples.
    acc_sum = acc_q;
    if (up && !dn) begin
      acc_sum = acc_q + ACC_ONE;
    end else if (dn && !up) begin
      acc_sum = acc_q - ACC_ONE;
    end

    win_end = (win_q == WIN_LAST);
    step_up = win_end && (acc_sum >= TH_POS);
    step_dn = win_end && (acc_sum <= TH_NEG);

    unique case (state_q)
      ST_INIT, ST_RECOVER: begin
        dcode_d = '0;
        acc_d   = '0;
        win_d   = '0;
        lock_d  = '0;
        if (harm) begin
          hold_d = '0;
        end else if (hold_q == HOLD_LAST) begin
          hold_d  = '0;
          state_d = ST_TRACK;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end

      ST_TRACK, ST_LOCKED: begin
        if (harm) begin
          // Harmonic recovery overrides any decision in this cycle.
          state_d = ST_RECOVER;
          dcode_d = '0;
          acc_d   = '0;
          win_d   = '0;
          lock_d  = '0;
          hold_d  = '0;
        end else begin
          if (win_end) begin
            acc_d = '0;
            win_d = '0;
          end else begin
            acc_d = acc_sum;
            win_d = win_q + 1'b1;
          end

          if (step_up && (dcode_q != CODE_MAX)) dcode_d = dcode_q + 1'b1;
          if (step_dn && (dcode_q != '0))       dcode_d = dcode_q - 1'b1;

          // A saturated step still counts as activity, not a quiet window.
          if (step_up || step_dn) begin
            lock_d  = '0;
            state_d = ST_TRACK;
          end else if (win_end && (state_q == ST_TRACK)) begin
            lock_d = lock_q + 1'b1;
            if (lock_d == LOCK_TGT) state_d = ST_LOCKED;
          end
        end
      end

      default: state_d = ST_INIT;
    endcase

    // Derived from the next state so locked/pd_en change on the same edge
    // as the state.
    pd_en_d  = (state_d == ST_TRACK) || (state_d == ST_LOCKED);
    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk_ext or posedge rst) begin
    if (rst) begin
      state_q  <= ST_INIT;
      dcode_q  <= '0;
      pd_en_q  <= 1'b0;
      locked_q <= 1'b0;
      acc_q    <= '0;
      win_q    <= '0;
      lock_q   <= '0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      dcode_q  <= dcode_d;
      pd_en_q  <= pd_en_d;
      locked_q <= locked_d;
      acc_q    <= acc_d;
      win_q    <= win_d;
      lock_q   <= lock_d;
      hold_q   <= hold_d;
    end
  end

  assign dcode  = dcode_q;
  assign pd_en  = pd_en_q;
  assign locked = locked_q;

endmodule

// File: tb/tb_dll_code_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dll_code_ctrl: self-checking bench for dll_code_ctrl.
// A behavioural model (window sample queue, settle counter, quiet-window run
// length) predicts dcode/pd_en/locked after every clock edge; directed
// scenarios add fixed expectations on top of the model comparisons.
// ---------------------------------------------------------------------------
module tb_dll_code_ctrl;

  localparam int CODE_W   = 6;
  localparam int WIN      = 8;
  localparam int TH       = 3;
  localparam int LOCK_CNT = 4;
  localparam int HOLD_CYC = 16;
  localparam int CODE_MAX = (1 << CODE_W) - 1;

  logic              clk_ext;
  logic              rst;
  logic              Reset_PD;
  logic              up;
  logic              dn;
  logic [CODE_W-1:0] dcode;
  logic              pd_en;
  logic              locked;

  int n_checks = 0;
  int n_errors = 0;

  dll_code_ctrl #(
    .CODE_W   (CODE_W),
    .WIN      (WIN),
    .TH       (TH),
    .LOCK_CNT (LOCK_CNT),
    .HOLD_CYC (HOLD_CYC)
  ) dut (
    .clk_ext  (clk_ext),
    .rst      (rst),
    .Reset_PD (Reset_PD),
    .up       (up),
    .dn       (dn),
    .dcode    (dcode),
    .pd_en    (pd_en),
    .locked   (locked)
  );

  initial clk_ext = 1'b0;
  always #5 clk_ext = ~clk_ext;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------ model
  typedef enum {M_INIT, M_TRACK, M_LOCKED, M_RECOVER} mode_e;

  mode_e m_mode;
  int    m_code;
  int    m_settle;   // clean (no-harmonic) cycles seen while settling
  int    m_quiet;    // consecutive quiet windows
  int    m_win[$];   // samples of the current window (+1/-1/0)
  bit    m_rp[$];    // Reset_PD samples in flight through the synchronizer

  task automatic model_reset();
    m_mode   = M_INIT;
    m_code   = 0;
    m_settle = 0;
    m_quiet  = 0;
    m_win.delete();
    m_rp.delete();
    m_rp.push_back(1'b1);
    m_rp.push_back(1'b1);
  endtask

  task automatic model_step();
    bit h;
    int sum;
    bit stepped;
    // The harmonic flag seen at this edge is Reset_PD from two edges ago.
    h = !m_rp.pop_front();
    m_rp.push_back(Reset_PD);
    case (m_mode)
      M_INIT, M_RECOVER: begin
        if (h) begin
          m_settle = 0;
        end else begin
          m_settle++;
          if (m_settle == HOLD_CYC) begin
            m_mode   = M_TRACK;
            m_settle = 0;
          end
        end
      end
      default: begin
        if (h) begin
          m_mode   = M_RECOVER;
          m_code   = 0;
          m_settle = 0;
          m_quiet  = 0;
          m_win.delete();
        end else begin
          m_win.push_back((up && !dn) ? 1 : ((dn && !up) ? -1 : 0));
          if (m_win.size() == WIN) begin
            sum = 0;
            foreach (m_win[i]) sum += m_win[i];
            m_win.delete();
            stepped = 1'b0;
            if (sum >= TH) begin
              if (m_code < CODE_MAX) m_code++;
              stepped = 1'b1;
            end else if (sum <= -TH) begin
              if (m_code > 0) m_code--;
              stepped = 1'b1;
            end
            if (stepped) begin
              m_quiet = 0;
              m_mode  = M_TRACK;
            end else if (m_mode == M_TRACK) begin
              m_quiet++;
              if (m_quiet == LOCK_CNT) m_mode = M_LOCKED;
            end
          end
        end
      end
    endcase
  endtask

  // One clock: model follows the edge, outputs compared 1 time unit later.
  task automatic tick();
    @(posedge clk_ext);
    if (rst) model_reset();
    else     model_step();
    #1;
    check("dcode",  int'(dcode),  m_code);
    check("pd_en",  int'(pd_en),  int'(m_mode == M_TRACK || m_mode == M_LOCKED));
    check("locked", int'(locked), int'(m_mode == M_LOCKED));
  endtask

  task automatic drive(input int n, input bit u, input bit d);
    for (int i = 0; i < n; i++) begin
      up = u;
      dn = d;
      tick();
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    up       = 1'b0;
    dn       = 1'b0;
    Reset_PD = 1'b1;
    model_reset();
    repeat (2) tick();
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    up       = 1'b0;
    dn       = 1'b0;
    Reset_PD = 1'b1;
    model_reset();

    // INIT: 16 settle cycles, then 4 quiet windows to lock.
    do_reset();
    check("rst_dcode", int'(dcode), 0);
    repeat (15) tick();
    check("init_pd_en_c15", int'(pd_en), 0);
    tick();
    check("init_pd_en_c16", int'(pd_en), 1);
    check("init_dcode", int'(dcode), 0);
    repeat (31) tick();
    check("lock_before", int'(locked), 0);
    tick();
    check("lock_after_4win", int'(locked), 1);

    // Step up: 3 up samples in a window steps; 2 do not.
    drive(3, 1'b1, 1'b0);
    drive(4, 1'b0, 1'b0);
    check("step_before_end", int'(dcode), 0);
    drive(1, 1'b0, 1'b0);
    check("step_up_3", int'(dcode), 1);
    check("step_unlocks", int'(locked), 0);
    drive(2, 1'b1, 1'b0);
    drive(6, 1'b0, 1'b0);
    check("no_step_2", int'(dcode), 1);

    // Saturation at both ends.
    drive(70 * WIN, 1'b1, 1'b0);
    check("sat_top", int'(dcode), CODE_MAX);
    check("sat_top_unlocked", int'(locked), 0);
    drive(70 * WIN, 1'b0, 1'b1);
    check("sat_bottom", int'(dcode), 0);
    check("sat_bottom_unlocked", int'(locked), 0);

    // Simultaneous up and dn cancel: quiet windows lead to lock.
    drive(4 * WIN - 1, 1'b1, 1'b1);
    check("simul_not_yet", int'(locked), 0);
    drive(1, 1'b1, 1'b1);
    check("simul_lock", int'(locked), 1);
    check("simul_dcode", int'(dcode), 0);

    // Harmonic recovery from dcode=20 while locked.
    drive(20 * WIN, 1'b1, 1'b0);
    drive(4 * WIN, 1'b0, 1'b0);
    check("harm_pre_dcode", int'(dcode), 20);
    check("harm_pre_locked", int'(locked), 1);
    Reset_PD = 1'b0;
    drive(2, 1'b0, 1'b0);
    check("harm_sync_lat", int'(dcode), 20);
    drive(1, 1'b0, 1'b0);
    check("harm_dcode", int'(dcode), 0);
    check("harm_locked", int'(locked), 0);
    check("harm_pd_en", int'(pd_en), 0);
    drive(2, 1'b1, 1'b0);
    Reset_PD = 1'b1;
    drive(17, 1'b0, 1'b0);
    check("harm_hold_c17", int'(pd_en), 0);
    drive(1, 1'b0, 1'b0);
    check("harm_release", int'(pd_en), 1);

    // Randomized segments with harmonic bursts, checked against the model.
    for (int seg = 0; seg < 10; seg++) begin
      int pu;
      int pd;
      pu = int'($urandom_range(0, 100));
      pd = int'($urandom_range(0, 100));
      for (int c = 0; c < 200; c++) begin
        up = ($urandom_range(0, 99) < pu);
        dn = ($urandom_range(0, 99) < pd);
        Reset_PD = ($urandom_range(0, 399) != 0);
        tick();
      end
      if (seg % 2 == 0) begin
        Reset_PD = 1'b0;
        repeat (int'($urandom_range(1, 4))) tick();
        Reset_PD = 1'b1;
      end
    end

    // Asynchronous reset mid-window with dcode=9.
    do_reset();
    drive(HOLD_CYC, 1'b0, 1'b0);
    drive(9 * WIN, 1'b1, 1'b0);
    check("pre_rst_dcode", int'(dcode), 9);
    drive(3, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_dcode", int'(dcode), 0);
    check("async_rst_pd_en", int'(pd_en), 0);
    check("async_rst_locked", int'(locked), 0);
    model_reset();
    repeat (2) tick();
    rst = 1'b0;

    // Restart in INIT, with a harmonic glitch restarting the settle count.
    drive(5, 1'b0, 1'b0);
    Reset_PD = 1'b0;
    drive(2, 1'b0, 1'b0);
    Reset_PD = 1'b1;
    drive(HOLD_CYC, 1'b0, 1'b0);
    check("init_restarted", int'(pd_en), 0);
    drive(5 * WIN, 1'b0, 1'b0);
    check("final_locked", int'(locked), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dll_code_ctrl.md
DLL_CODE_CTRL -- requirements
Module: dll_code_ctrl

Interface
REQ-001 SHALL have parameter CODE_W, default 6: delay-line control code width.
REQ-002 SHALL have parameter WIN, default 8: phase-detector integration window in cycles, power of two.
REQ-003 SHALL have parameter TH, default 3: net up/dn count that triggers one code step.
REQ-004 SHALL have parameter LOCK_CNT, default 4: consecutive quiet windows required to declare lock.
REQ-005 SHALL have parameter HOLD_CYC, default 16: settle time in cycles after init or harmonic recovery.
REQ-006 SHALL have port clk_ext, input, 1 bit: the single clock; all state on the rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-008 SHALL have port Reset_PD, input, 1 bit: harmonic-lock-detector output, asynchronous to clk_ext; low means false/harmonic lock was detected.
REQ-009 SHALL have port up, input, 1 bit: phase-detector "delay too short" pulse.
REQ-010 SHALL have port dn, input, 1 bit: phase-detector "delay too long" pulse.
REQ-011 SHALL have port dcode, output, CODE_W bits: delay-line control code.
REQ-012 SHALL have port pd_en, output, 1 bit: phase-detector enable; low holds the PD in reset.
REQ-013 SHALL have port locked, output, 1 bit: DLL lock indication.

Function
REQ-014 Reset_PD SHALL pass through a 2-flop synchronizer; harm = inverted synchronized value, 2-cycle latency.
REQ-015 The FSM SHALL have the states INIT, TRACK, LOCKED and RECOVER.
REQ-016 INIT SHALL hold dcode=0 and pd_en=0 and count HOLD_CYC cycles, then go to TRACK; harm=1 during INIT SHALL restart the count.
REQ-017 In TRACK and LOCKED, pd_en SHALL be 1 and the window logic SHALL run.
REQ-018 Window logic, each cycle: up&~dn adds +1 to the signed accumulator acc; dn&~up adds -1; both high or both low add 0.
REQ-019 acc SHALL be at least clog2(WIN)+2 bits signed and SHALL never overflow.
REQ-020 A window counter SHALL run 0..WIN-1 and wrap; at count WIN-1 the final sample is included, a decision is taken, and acc clears to 0 on the next cycle.
REQ-021 Decision acc>=TH: dcode+1, saturating at 2^CODE_W-1.
REQ-022 Decision acc<=-TH: dcode-1, saturating at 0.
REQ-023 Any other decision SHALL leave dcode unchanged (quiet window).
REQ-024 dcode SHALL change exactly one cycle after the decision cycle, by at most 1 per window.
REQ-025 A saturated step (no actual change) SHALL count as a step, not as a quiet window.
REQ-026 Quiet windows SHALL increment a lock counter; any step SHALL clear it.
REQ-027 When the lock counter reaches LOCK_CNT, TRACK SHALL go to LOCKED and locked SHALL assert in the same cycle that the state changes.
REQ-028 In LOCKED, a step SHALL return the FSM to TRACK, deassert locked and clear the lock counter; the step is still applied.
REQ-029 harm=1 in TRACK or LOCKED SHALL enter RECOVER on the next edge and take priority over a simultaneous window decision.
REQ-030 RECOVER SHALL force dcode=0, locked=0 and pd_en=0, clear acc, the window counter and the lock counter, and reload the hold counter.
REQ-031 RECOVER SHALL exit to TRACK only after HOLD_CYC consecutive cycles with harm=0; harm=1 reloads the hold counter.
REQ-032 Outputs SHALL be registered, with no combinational path from up, dn or Reset_PD to any output.

Reset
REQ-033 rst=1 SHALL asynchronously force state INIT, dcode=0, pd_en=0, locked=0, clear acc and all counters, and set the synchronizer flops to 1 (no harmonic).
REQ-034 Deassertion of rst SHALL be synchronized externally; assertion mid-operation SHALL take effect immediately without waiting for a clock.

Structure
REQ-035 The FSM state encoding and the default values of CODE_W, WIN, TH, LOCK_CNT and HOLD_CYC SHALL live in the shared package dll_pkg.
REQ-036 The 2-flop synchronizer SHALL be the single sub-module sync2, reused for other asynchronous inputs.

Verification
REQ-037 Scenario (INIT): rst pulse, up=dn=0 -> dcode=0 and pd_en=0 for 16 cycles, pd_en=1 from cycle 17, locked=1 after 4 windows (32 cycles).
REQ-038 Scenario (step up): in TRACK, up=1 for 3 cycles of an 8-cycle window -> dcode 0->1 one cycle after the window end; with up=1 for only 2 cycles -> no change.
REQ-039 Scenario (saturation): up=1 held for 70 windows -> dcode stops at 63, locked stays 0; dn=1 held at dcode=0 -> dcode stays 0.
REQ-040 Scenario (simultaneous): up=dn=1 every cycle -> acc stays 0, quiet windows accumulate, locked=1 after 4 windows.
REQ-041 Scenario (harmonic): dcode=20 and locked=1, drive Reset_PD=0 -> within 3 cycles dcode=0, locked=0, pd_en=0; release -> pd_en=1 after 16 clean cycles.
REQ-042 Scenario (reset mid-window): assert rst asynchronously mid-window with dcode=9 -> all outputs 0 immediately, the FSM restarts in INIT.
